// File: rtl/cache_victim_buffer_pkg.sv
// Shared types for the victim buffer: drain state encoding.
package cache_victim_buffer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } drain_state_t;

endpackage

// File: rtl/cache_victim_buffer_linebeatselect.sv
// Combinational beat mux: picks one bus beat out of a cache line, beat 0 = LSBs.
module linebeatselect #(
  parameter int LINELEN = 512,
  parameter int BEATLEN = 64
) (
  input  logic [LINELEN-1:0]                  line,
  input  logic [$clog2(LINELEN/BEATLEN)-1:0]  beat,
  output logic [BEATLEN-1:0]                  data
);

  assign data = line[beat*BEATLEN +: BEATLEN];

endmodule

// File: rtl/flopenr.sv
// Resettable register primitive with load enable (synchronous, active-high reset).
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d only when enabled, clearing on reset.
  always_ff @(posedge clk)
    if (reset)   q <= '0;
    else if (en) q <= d;

endmodule

// File: rtl/flopr.sv
// Resettable register primitive (synchronous, active-high reset to zero).
module flopr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d every cycle, clearing on reset.
  always_ff @(posedge clk)
    if (reset) q <= '0;
    else       q <= d;

endmodule

// File: rtl/cache_victim_buffer.sv
// Victim buffer: queues evicted dirty lines and drains each one to the bus as an
// address-incrementing burst of beats. A lookup port reports whether a line is
// still waiting to be written back so a refill of that line can be stalled.
module cache_victim_buffer
  import cache_victim_buffer_pkg::*;
#(
  parameter int PA_BITS = 32,
  parameter int LINELEN = 512,
  parameter int BEATLEN = 64,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               EvictValid,
  output logic               EvictReady,
  input  logic [PA_BITS-1:0] EvictAdr,
  input  logic [LINELEN-1:0] EvictLine,
  output logic               BusValid,
  input  logic               BusReady,
  output logic [PA_BITS-1:0] BusAdr,
  output logic [BEATLEN-1:0] BusData,
  output logic               BusLast,
  input  logic [PA_BITS-1:0] LookupAdr,
  output logic               LookupMatch,
  output logic               Empty
);

  localparam int BEATS     = LINELEN / BEATLEN;
  localparam int OFFSETLEN = $clog2(LINELEN / 8);
  localparam int PTRW      = $clog2(DEPTH);
  localparam int CNTW      = PTRW + 1;
  localparam int BEATW     = $clog2(BEATS);

  logic [PA_BITS-1:0] adr_mem  [DEPTH];
  logic [LINELEN-1:0] line_mem [DEPTH];

  logic [PTRW-1:0]  wr_ptr, rd_ptr, rel;
  logic [CNTW-1:0]  count, count_next;
  logic [BEATW-1:0] beat, beat_next;
  logic             state_bits;
  drain_state_t     state, next_state;

  logic               full, empty, push, pop, bus_valid, last_beat, lookup_hit;
  logic [PA_BITS-1:0] entry_adr, beat_offset;
  logic [BEATLEN-1:0] beat_data;
  logic               unused_low_bits;

  assign full  = (count == CNTW'(DEPTH));
  assign empty = (count == '0);

  // Ready depends only on the registered count, so a pop never frees a slot in the same cycle.
  assign EvictReady = ~full;
  assign push       = EvictValid & ~full;

  assign bus_valid = (state == BURST);
  assign last_beat = (beat == BEATW'(BEATS - 1));
  assign pop       = bus_valid & BusReady & last_beat;

  // Entry storage is written on push only and never cleared; occupancy tracks validity.
  always_ff @(posedge clk)
    if (push) begin
      adr_mem[wr_ptr]  <= {EvictAdr[PA_BITS-1:OFFSETLEN], OFFSETLEN'(0)};
      line_mem[wr_ptr] <= EvictLine;
    end

  flopenr #(.WIDTH(PTRW)) wr_ptr_reg (
    .clk(clk), .reset(reset), .en(push), .d(wr_ptr + PTRW'(1)), .q(wr_ptr)
  );

  flopenr #(.WIDTH(PTRW)) rd_ptr_reg (
    .clk(clk), .reset(reset), .en(pop), .d(rd_ptr + PTRW'(1)), .q(rd_ptr)
  );

  // Occupancy changes only when exactly one of push/pop happens.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNTW'(1);
      2'b01:   count_next = count - CNTW'(1);
      default: count_next = count;
    endcase
  end

  flopr #(.WIDTH(CNTW)) count_reg (
    .clk(clk), .reset(reset), .d(count_next), .q(count)
  );

  // Drain FSM: a push into an idle buffer starts the burst on the same edge, and a
  // popped entry with another one behind it rolls straight into the next burst.
  always_comb begin
    next_state = state;
    beat_next  = beat;
    case (state)
      IDLE: begin
        beat_next = '0;
        if (!empty || push) next_state = BURST;
      end
      BURST: begin
        if (BusReady) begin
          if (last_beat) begin
            beat_next  = '0;
            next_state = (count > CNTW'(1)) ? BURST : IDLE;
          end else begin
            beat_next = beat + BEATW'(1);
          end
        end
      end
      default: begin
        next_state = IDLE;
        beat_next  = '0;
      end
    endcase
  end

  flopr #(.WIDTH(1)) state_reg (
    .clk(clk), .reset(reset), .d(next_state), .q(state_bits)
  );
  assign state = drain_state_t'(state_bits);

  flopr #(.WIDTH(BEATW)) beat_reg (
    .clk(clk), .reset(reset), .d(beat_next), .q(beat)
  );

  assign entry_adr = adr_mem[rd_ptr];

  linebeatselect #(.LINELEN(LINELEN), .BEATLEN(BEATLEN)) beat_mux (
    .line(line_mem[rd_ptr]), .beat(beat), .data(beat_data)
  );

  // Entry addresses are line-aligned, so adding the beat offset never carries out of the offset field.
  assign beat_offset = PA_BITS'(beat) * PA_BITS'(BEATLEN / 8);

  assign BusValid = bus_valid;
  assign BusAdr   = bus_valid ? (entry_adr + beat_offset) : '0;
  assign BusData  = bus_valid ? beat_data : '0;
  assign BusLast  = bus_valid & last_beat;
  assign Empty    = empty;

  // Match the lookup line against every occupied slot, counting from the read pointer.
  always_comb begin
    lookup_hit = 1'b0;
    rel        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = PTRW'(i) - rd_ptr;
      if (({1'b0, rel} < count) &&
          (adr_mem[i][PA_BITS-1:OFFSETLEN] == LookupAdr[PA_BITS-1:OFFSETLEN]))
        lookup_hit = 1'b1;
    end
  end

  assign LookupMatch = lookup_hit;

  assign unused_low_bits = ^{LookupAdr[OFFSETLEN-1:0], EvictAdr[OFFSETLEN-1:0]};

endmodule

// File: tb/tb_cache_victim_buffer.sv
// Directed self-checking bench for cache_victim_buffer (32-bit PA, 512-bit lines, 64-bit beats, 2 entries).
module tb_cache_victim_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         EvictValid;
  logic         EvictReady;
  logic [31:0]  EvictAdr;
  logic [511:0] EvictLine;
  logic         BusValid;
  logic         BusReady;
  logic [31:0]  BusAdr;
  logic [63:0]  BusData;
  logic         BusLast;
  logic [31:0]  LookupAdr;
  logic         LookupMatch;
  logic         Empty;

  int vectors     = 0;
  int miscompares = 0;

  cache_victim_buffer #(
    .PA_BITS(32), .LINELEN(512), .BEATLEN(64), .DEPTH(2)
  ) dut (
    .clk(clk), .reset(reset),
    .EvictValid(EvictValid), .EvictReady(EvictReady),
    .EvictAdr(EvictAdr), .EvictLine(EvictLine),
    .BusValid(BusValid), .BusReady(BusReady),
    .BusAdr(BusAdr), .BusData(BusData), .BusLast(BusLast),
    .LookupAdr(LookupAdr), .LookupMatch(LookupMatch),
    .Empty(Empty)
  );

  always #5 clk = ~clk;

  // Line whose 64-bit word k holds base + k.
  function automatic logic [511:0] mkline(input logic [63:0] base);
    logic [511:0] l;
    l = '0;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + 64'(k);
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] adr, input logic [63:0] base);
    EvictValid = valid;
    EvictAdr   = adr;
    EvictLine  = mkline(base);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drains beats first_beat..7 of the line at base with BusReady held high.
  task automatic drain_check(input logic [31:0] base, input int first_beat);
    for (int k = first_beat; k < 8; k++) begin
      BusReady = 1'b1;
      #2;
      checkOutput("drain_valid", 64'(BusValid), 64'(1'b1));
      checkOutput("drain_adr", 64'(BusAdr), 64'(base + 32'(k * 8)));
      checkOutput("drain_data", BusData, 64'(base) + 64'(k));
      checkOutput("drain_last", 64'(BusLast), 64'(k == 7));
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int eb;
    int cyc;

    reset     = 1'b1;
    BusReady  = 1'b0;
    LookupAdr = '0;
    applyStimulus(1'b0, 32'h0, 64'h0);
    tick();
    tick();
    reset = 1'b0;
    #2;
    checkOutput("rst_evict_ready", 64'(EvictReady), 64'(1'b1));
    checkOutput("rst_bus_valid", 64'(BusValid), 64'(1'b0));
    checkOutput("rst_bus_last", 64'(BusLast), 64'(1'b0));
    checkOutput("rst_bus_adr", 64'(BusAdr), 64'h0);
    checkOutput("rst_bus_data", BusData, 64'h0);
    checkOutput("rst_empty", 64'(Empty), 64'(1'b1));
    checkOutput("rst_lookup", 64'(LookupMatch), 64'(1'b0));
    tick();

    $display("[TB] single line with lookup");
    applyStimulus(1'b1, 32'h8000_0040, 64'h0);
    BusReady  = 1'b1;
    LookupAdr = 32'h8000_0058;
    #2;
    checkOutput("single_push_ready", 64'(EvictReady), 64'(1'b1));
    checkOutput("single_pre_valid", 64'(BusValid), 64'(1'b0));
    checkOutput("single_pre_lookup", 64'(LookupMatch), 64'(1'b0));
    tick();
    applyStimulus(1'b0, 32'h0, 64'h0);
    for (int k = 0; k < 8; k++) begin
      #2;
      checkOutput("single_valid", 64'(BusValid), 64'(1'b1));
      checkOutput("single_adr", 64'(BusAdr), 64'(32'h8000_0040 + 32'(k * 8)));
      checkOutput("single_data", BusData, 64'(k));
      checkOutput("single_last", 64'(BusLast), 64'(k == 7));
      checkOutput("single_empty", 64'(Empty), 64'(1'b0));
      checkOutput("lookup_hit", 64'(LookupMatch), 64'(1'b1));
      LookupAdr = 32'h8000_0080;
      #1;
      checkOutput("lookup_miss", 64'(LookupMatch), 64'(1'b0));
      LookupAdr = 32'h8000_0058;
      tick();
    end
    #2;
    checkOutput("single_after_empty", 64'(Empty), 64'(1'b1));
    checkOutput("single_after_valid", 64'(BusValid), 64'(1'b0));
    checkOutput("single_after_lookup", 64'(LookupMatch), 64'(1'b0));
    checkOutput("single_after_adr", 64'(BusAdr), 64'h0);
    tick();

    $display("[TB] backpressure");
    applyStimulus(1'b1, 32'h8000_0040, 64'd100);
    tick();
    applyStimulus(1'b0, 32'h0, 64'h0);
    eb  = 0;
    cyc = 0;
    while (eb < 8 && cyc < 40) begin
      BusReady = (cyc % 3 == 0);
      #2;
      checkOutput("bp_valid", 64'(BusValid), 64'(1'b1));
      checkOutput("bp_adr", 64'(BusAdr), 64'(32'h8000_0040 + 32'(eb * 8)));
      checkOutput("bp_data", BusData, 64'd100 + 64'(eb));
      checkOutput("bp_last", 64'(BusLast), 64'(eb == 7));
      tick();
      if (BusReady) eb++;
      cyc++;
    end
    checkOutput("bp_all_beats", 64'(eb), 64'd8);
    BusReady = 1'b1;
    #2;
    checkOutput("bp_empty", 64'(Empty), 64'(1'b1));
    tick();

    $display("[TB] full buffer");
    BusReady = 1'b0;
    applyStimulus(1'b1, 32'h0000_1000, 64'h1000);
    #2;
    checkOutput("full_ready0", 64'(EvictReady), 64'(1'b1));
    tick();
    applyStimulus(1'b1, 32'h0000_2000, 64'h2000);
    #2;
    checkOutput("full_ready1", 64'(EvictReady), 64'(1'b1));
    tick();
    applyStimulus(1'b1, 32'h0000_3000, 64'h3000);
    #2;
    checkOutput("full_ready2", 64'(EvictReady), 64'(1'b0));
    checkOutput("full_head_adr", 64'(BusAdr), 64'h1000);
    tick();
    applyStimulus(1'b0, 32'h0, 64'h0);
    #2;
    checkOutput("full_hold_adr", 64'(BusAdr), 64'h1000);
    checkOutput("full_hold_data", BusData, 64'h1000);
    drain_check(32'h0000_1000, 0);
    drain_check(32'h0000_2000, 0);
    #2;
    checkOutput("full_empty", 64'(Empty), 64'(1'b1));
    checkOutput("full_no_third", 64'(BusValid), 64'(1'b0));
    tick();

    $display("[TB] pop while full");
    BusReady = 1'b0;
    applyStimulus(1'b1, 32'h0000_4000, 64'h4000);
    tick();
    applyStimulus(1'b1, 32'h0000_5000, 64'h5000);
    tick();
    applyStimulus(1'b0, 32'h0, 64'h0);
    for (int k = 0; k < 7; k++) begin
      BusReady = 1'b1;
      #2;
      checkOutput("pwf_adr", 64'(BusAdr), 64'(32'h4000 + 32'(k * 8)));
      tick();
    end
    applyStimulus(1'b1, 32'h0000_6000, 64'h6000);
    #2;
    checkOutput("pwf_last", 64'(BusLast), 64'(1'b1));
    checkOutput("pwf_not_ready", 64'(EvictReady), 64'(1'b0));
    checkOutput("pwf_last_adr", 64'(BusAdr), 64'h4038);
    tick();
    #2;
    checkOutput("pwf_ready_next", 64'(EvictReady), 64'(1'b1));
    checkOutput("pwf_next_adr", 64'(BusAdr), 64'h5000);
    checkOutput("pwf_next_data", BusData, 64'h5000);
    tick();
    applyStimulus(1'b0, 32'h0, 64'h0);
    drain_check(32'h0000_5000, 1);
    drain_check(32'h0000_6000, 0);
    #2;
    checkOutput("pwf_empty", 64'(Empty), 64'(1'b1));
    tick();

    $display("[TB] reset mid-burst");
    applyStimulus(1'b1, 32'h0000_7000, 64'h7000);
    BusReady = 1'b1;
    tick();
    applyStimulus(1'b0, 32'h0, 64'h0);
    drain_check(32'h0000_7000, 0);
    #0;
    checkOutput("rmb_unused_guard", 64'(Empty), 64'(1'b1));
    tick();
    applyStimulus(1'b1, 32'h0000_7000, 64'h7000);
    tick();
    applyStimulus(1'b0, 32'h0, 64'h0);
    for (int k = 0; k < 3; k++) begin
      #2;
      checkOutput("rmb_pre_adr", 64'(BusAdr), 64'(32'h7000 + 32'(k * 8)));
      tick();
    end
    reset = 1'b1;
    #2;
    checkOutput("rmb_beat3_adr", 64'(BusAdr), 64'h7018);
    tick();
    reset     = 1'b0;
    LookupAdr = 32'h0000_7000;
    #2;
    checkOutput("rmb_valid", 64'(BusValid), 64'(1'b0));
    checkOutput("rmb_empty", 64'(Empty), 64'(1'b1));
    checkOutput("rmb_ready", 64'(EvictReady), 64'(1'b1));
    checkOutput("rmb_lookup", 64'(LookupMatch), 64'(1'b0));
    checkOutput("rmb_last", 64'(BusLast), 64'(1'b0));
    tick();
    applyStimulus(1'b1, 32'h0000_9000, 64'h9000);
    tick();
    applyStimulus(1'b0, 32'h0, 64'h0);
    drain_check(32'h0000_9000, 0);
    #2;
    checkOutput("rmb_final_empty", 64'(Empty), 64'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_victim_buffer.md
# cache_victim_buffer

Holds dirty cache lines evicted from the way chosen by the cache replacement logic, then drains them to the bus interface as address-incrementing beat bursts. It sits between the cache data array and the bus fetch/writeback path. The cache can complete a refill before the old line has finished writing back. A line-address lookup port lets the cache controller stall a refill whose line is still queued for writeback.

## Interface
Parameters:
- `PA_BITS`, 32: physical address width.
- `LINELEN`, 512: cache line width in bits.
- `BEATLEN`, 64: bus beat width in bits. `LINELEN` must be a multiple of it, and `BEATS = LINELEN/BEATLEN` must be a power of 2, ≥2.
- `DEPTH`, 2: number of line entries. Must be a power of 2, ≥2.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `EvictValid`, in, 1: evicted line presented.
- `EvictReady`, out, 1: buffer can accept a line.
- `EvictAdr`, in, `PA_BITS`: line-aligned address of the evicted line. Low `OFFSETLEN = $clog2(LINELEN/8)` bits are ignored and stored as 0.
- `EvictLine`, in, `LINELEN`: line data.
- `BusValid`, out, 1: beat valid.
- `BusReady`, in, 1: bus accepts the beat.
- `BusAdr`, out, `PA_BITS`: byte address of the current beat.
- `BusData`, out, `BEATLEN`: beat data.
- `BusLast`, out, 1: final beat of the line.
- `LookupAdr`, in, `PA_BITS`: address to check against pending lines.
- `LookupMatch`, out, 1: `LookupAdr` line matches a pending entry.
- `Empty`, out, 1: no entries pending.

## Operation
- **Storage.** Circular FIFO of `DEPTH` entries, each `{address, line}`, with write pointer, read pointer and occupancy count.
  - Pointers are `$clog2(DEPTH)` bits wide and wrap naturally.
  - The count is `$clog2(DEPTH)+1` bits wide.
  - `Full = (count == DEPTH)`; `Empty = (count == 0)`.
- **Push.** Occurs when `EvictValid & EvictReady`. `EvictReady = ~Full`, with no bypass: a pop in the same cycle does not make a full buffer ready.
- **Drain FSM** has two states, IDLE and BURST.
  - IDLE → BURST when `~Empty`. The beat counter is cleared to 0.
  - In BURST, `BusValid = 1`. On `BusReady`, the beat counter increments.
  - On a `BusReady` handshake with `BusLast`, the entry pops (read pointer +1, count −1). The FSM then returns to IDLE, or stays in BURST with the counter reset to 0 if `count > 1` before the pop.
- **Beat counter** is `$clog2(BEATS)` bits wide. `BusLast = BusValid & (beat == BEATS-1)`.
- **Beat data.** `BusData` is `line[beat*BEATLEN +: BEATLEN]`, so beat 0 carries the LSBs.
- **Beat address.** `BusAdr = entryAdr + beat*(BEATLEN/8)`, computed modulo 2^`PA_BITS`. The beat offset never carries past the line offset field.
- **Idle outputs.** When `BusValid = 0`, `BusAdr`, `BusData` and `BusLast` are all 0.
- **Valid/ready hold.** Once `BusValid` rises, it and `BusAdr`/`BusData` stay stable until `BusReady`.
- **Lookup.** `LookupMatch` is combinational. It compares `LookupAdr[PA_BITS-1:OFFSETLEN]` against every occupied entry, including the one in BURST.
  - An entry still matches during the cycle of its final handshake.
  - It stops matching the following cycle.
- **Simultaneous push and pop** (not full): count is unchanged and both pointers advance.
- **Reset,** including mid-burst: the FSM goes to IDLE and pointers and count go to 0. Entry storage is not cleared.
  - Output values after reset: `EvictReady = 1`, `BusValid = 0`, `BusLast = 0`, `BusAdr = 0`, `BusData = 0`, `Empty = 1`, `LookupMatch = 0`.

## Timing
- Push → `BusValid`: 1 cycle. A line pushed at edge N is presented with `BusValid` after edge N, i.e. in cycle N+1, when starting from IDLE.
- One beat per cycle with `BusReady` held at 1. A line drains in `BEATS` cycles.
- Back-to-back entries incur no idle cycle: beat 0 of the next entry follows the `BusLast` handshake directly.
- Pop → `EvictReady` rise: 1 cycle, because count is registered.
- There is no combinational path from `BusReady` to `EvictReady` or from `EvictValid` to `BusValid`.

## Structure
- No shared package types are needed. `BEATS`, `OFFSETLEN` and the pointer widths are localparams derived from the parameters.
- One sub-module, `linebeatselect` (`LINELEN`, `BEATLEN`): a combinational mux from line and beat index to beat data.
- Reuse the existing flop primitives (`flopenr`, `flopr`) for the pointers, count, FSM state and beat counter.

## Test plan
All scenarios use `PA_BITS=32`, `LINELEN=512`, `BEATLEN=64`, `DEPTH=2`.
- **Single line.** Push `EvictAdr=0x8000_0040` with line word k = k, `BusReady=1` → `BusValid` from the next cycle for 8 cycles. `BusAdr` = 0x80000040, 0x48, …, 0x78. `BusData` = 0..7. `BusLast` only on the 8th beat. `Empty=1` on the cycle after the last handshake.
- **Backpressure.** Same push with `BusReady` pattern 1,0,0,1,… → `BusAdr`/`BusData` are held through the 0 cycles, and no beat is skipped or duplicated.
- **Full.** Hold `BusReady=0` and push 0x1000 and then 0x2000 → `EvictReady=0`, and a third `EvictValid` is not accepted. Release `BusReady` → 0x1000 drains before 0x2000, 16 beats total, with no gap between lines.
- **Pop while full.** `EvictValid=1` on the final-beat handshake of the head entry → not accepted that cycle; accepted the next cycle; order preserved.
- **Lookup.** While 0x8000_0040 is pending: `LookupAdr=0x8000_0058` → 1; `0x8000_0080` → 0. Still 1 on the last-beat handshake cycle, 0 the cycle after.
- **Reset mid-burst.** Assert `reset` at beat 3 → the next cycle shows `BusValid=0`, `Empty=1`, `EvictReady=1` and `LookupMatch=0`. A new push then starts at beat 0.
